// File: rtl/rice_bus_csr_initiator_if.sv
// rice_bus_if: CSR request/response bus between one initiator and one slave.
// Latency: not applicable (signal bundle only).
// Backpressure: request_valid/request_ready and response_valid/response_ready handshakes.
// Signals: request_valid/ready, address (word), write_data, strobe (bit enables, 0 = read),
//          response_valid/ready, read_data, error.
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int BUS_WIDTH     = 32
) ();
    logic                     request_valid;
    logic                     request_ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH-1:0]     strobe;
    logic                     response_valid;
    logic                     response_ready;
    logic [BUS_WIDTH-1:0]     read_data;
    logic                     error;

    modport master (
        output request_valid, address, write_data, strobe, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, write_data, strobe, response_ready,
        output request_ready, response_valid, read_data, error
    );
endinterface

// File: rtl/rice_bus_csr_initiator.sv
// rice_bus_csr_initiator: client command/response to rice_bus_if CSR master, one transaction in flight.
// Latency: request_valid the cycle after command acceptance; client response the cycle after the bus response.
// Backpressure: o_cmd_ready low while busy; request held until request_ready; response held until i_rsp_ready.
// Ports: i_clk/i_rst (async, active high); client command i_cmd_* with o_cmd_ready;
//        client response o_rsp_* with i_rsp_ready; csr_if is the rice_bus_if master side.
module rice_bus_csr_initiator #(
    parameter int ADDRESS_WIDTH  = 14,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH-1:0]     i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_rsp_error,
    output logic                     o_rsp_timeout,
    rice_bus_if.master               csr_if
);

    localparam int BYTE_WIDTH  = BUS_WIDTH / 8;
    localparam int ADDRESS_LSB = $clog2(BYTE_WIDTH);
    localparam int WORD_WIDTH  = ADDRESS_WIDTH - ADDRESS_LSB;
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'((1 << ADDRESS_LSB) - 1);
    localparam logic [COUNT_WIDTH-1:0]   COUNT_LAST  =
        (TIMEOUT_CYCLES > 0) ? COUNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX   = '1;

    typedef struct packed {
        logic                  write;
        logic [WORD_WIDTH-1:0] address;
        logic [BUS_WIDTH-1:0]  write_data;
        logic [BUS_WIDTH-1:0]  strobe;
    } cmd_t;

    // DRAIN_RESP: client response pending and late slave response still owed.
    // DRAIN: client response accepted, late slave response still owed.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN,
        ST_DRAIN_RESP
    } state_t;

    state_t                 state;
    cmd_t                   cmd;
    logic [COUNT_WIDTH-1:0] count;
    logic                   request_valid;
    logic                   response_ready;
    logic                   misaligned;
    logic                   zero_strobe_write;
    logic                   timeout_hit;

    assign misaligned        = |(i_cmd_address & OFFSET_MASK);
    // The slave decodes strobe == 0 as a read, so such a write is completed locally.
    assign zero_strobe_write = i_cmd_write && (i_cmd_strobe == '0);
    assign timeout_hit       = (TIMEOUT_CYCLES != 0) && (count == COUNT_LAST);

    assign csr_if.request_valid  = request_valid;
    assign csr_if.address        = cmd.address;
    assign csr_if.write_data     = cmd.write_data;
    assign csr_if.strobe         = cmd.strobe;
    assign csr_if.response_ready = response_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            cmd             <= '0;
            count           <= '0;
            o_cmd_ready     <= 1'b1;
            o_rsp_valid     <= 1'b0;
            o_rsp_read_data <= '0;
            o_rsp_error     <= 1'b0;
            o_rsp_timeout   <= 1'b0;
            request_valid   <= 1'b0;
            response_ready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        cmd.write      <= i_cmd_write;
                        cmd.address    <= i_cmd_address[ADDRESS_WIDTH-1:ADDRESS_LSB];
                        cmd.write_data <= i_cmd_write_data;
                        // Reads always go out with a zero strobe.
                        cmd.strobe     <= i_cmd_write ? i_cmd_strobe : '0;
                        o_cmd_ready    <= 1'b0;
                        if (misaligned) begin
                            o_rsp_valid     <= 1'b1;
                            o_rsp_read_data <= '0;
                            o_rsp_error     <= 1'b1;
                            o_rsp_timeout   <= 1'b0;
                            state           <= ST_RESP;
                        end else if (zero_strobe_write) begin
                            o_rsp_valid     <= 1'b1;
                            o_rsp_read_data <= '0;
                            o_rsp_error     <= 1'b0;
                            o_rsp_timeout   <= 1'b0;
                            state           <= ST_RESP;
                        end else begin
                            request_valid <= 1'b1;
                            state         <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    // No timeout here: the request is held until the slave takes it.
                    if (csr_if.request_ready) begin
                        request_valid  <= 1'b0;
                        response_ready <= 1'b1;
                        count          <= '0;
                        state          <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // A response on the expiry cycle wins over the timeout.
                    if (csr_if.response_valid) begin
                        response_ready  <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_read_data <= cmd.write ? '0 : csr_if.read_data;
                        o_rsp_error     <= csr_if.error;
                        o_rsp_timeout   <= 1'b0;
                        state           <= ST_RESP;
                    end else if (timeout_hit) begin
                        // response_ready stays high to swallow the late response.
                        o_rsp_valid     <= 1'b1;
                        o_rsp_read_data <= '0;
                        o_rsp_error     <= 1'b1;
                        o_rsp_timeout   <= 1'b1;
                        state           <= ST_DRAIN_RESP;
                    end else if (count != COUNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid     <= 1'b0;
                        o_rsp_read_data <= '0;
                        o_rsp_error     <= 1'b0;
                        o_rsp_timeout   <= 1'b0;
                        o_cmd_ready     <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                ST_DRAIN_RESP: begin
                    // The late slave response and the client handshake retire independently;
                    // IDLE only once both are done so no stale response meets a new request.
                    if (csr_if.response_valid && i_rsp_ready) begin
                        response_ready  <= 1'b0;
                        o_rsp_valid     <= 1'b0;
                        o_rsp_read_data <= '0;
                        o_rsp_error     <= 1'b0;
                        o_rsp_timeout   <= 1'b0;
                        o_cmd_ready     <= 1'b1;
                        state           <= ST_IDLE;
                    end else if (csr_if.response_valid) begin
                        response_ready <= 1'b0;
                        state          <= ST_RESP;
                    end else if (i_rsp_ready) begin
                        o_rsp_valid     <= 1'b0;
                        o_rsp_read_data <= '0;
                        o_rsp_error     <= 1'b0;
                        o_rsp_timeout   <= 1'b0;
                        state           <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (csr_if.response_valid) begin
                        response_ready <= 1'b0;
                        o_cmd_ready    <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end

                default: begin
                    request_valid  <= 1'b0;
                    response_ready <= 1'b0;
                    o_rsp_valid    <= 1'b0;
                    o_cmd_ready    <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_bus_csr_initiator.sv
// tb_rice_bus_csr_initiator: directed bench with a transaction-level reference model.
// Latency: not applicable.
// Backpressure: bench slave holds request_ready low and delays responses per test.
`timescale 1ns/1ps
module tb_rice_bus_csr_initiator;
    localparam int AW = 14;
    localparam int BW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_address;
    logic [BW-1:0] cmd_write_data, cmd_strobe;
    logic          rsp_valid, rsp_ready;
    logic [BW-1:0] rsp_read_data;
    logic          rsp_error, rsp_timeout;

    always #5 clk = ~clk;

    rice_bus_if #(.ADDRESS_WIDTH(AW - 2), .BUS_WIDTH(BW)) bus ();

    rice_bus_csr_initiator #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(T)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_write      (cmd_write),
        .i_cmd_address    (cmd_address),
        .i_cmd_write_data (cmd_write_data),
        .i_cmd_strobe     (cmd_strobe),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_read_data  (rsp_read_data),
        .o_rsp_error      (rsp_error),
        .o_rsp_timeout    (rsp_timeout),
        .csr_if           (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave stimulus settings ----------------
    int          slv_hold  = 0;
    int          slv_delay = 0;   // negative: never respond
    logic [31:0] slv_data  = '0;
    logic        slv_err   = 1'b0;

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy, m_req, m_owed, m_cli, m_to;
    int          m_wait;
    logic        m_write;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_strobe, e_rdata;
    logic        e_err, e_to;

    // event log for literal checks
    int          cyc = 0, hs_cyc = 0, cli_cyc = 0, acc_cyc = 0;
    int          req_valid_cycles = 0, req_hs_cnt = 0, cli_cnt = 0;
    logic [11:0] seen_addr;
    logic [31:0] seen_strobe, seen_wdata, last_rdata;
    logic        last_err, last_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_req = 0; m_owed = 0; m_cli = 0; m_to = 0; m_wait = 0;
        end else begin
            cyc++;
            if (bus.request_valid === 1'b1) req_valid_cycles++;
            if (bus.request_valid === 1'b1 && bus.request_ready === 1'b1) begin
                req_hs_cnt++;
                hs_cyc      = cyc;
                seen_addr   = bus.address;
                seen_strobe = bus.strobe;
                seen_wdata  = bus.write_data;
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                cli_cnt++;
                cli_cyc    = cyc;
                last_rdata = rsp_read_data;
                last_err   = rsp_error;
                last_to    = rsp_timeout;
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cyc = cyc;

            if (!m_busy) begin
                if (cmd_valid) begin
                    m_write  = cmd_write;
                    e_addr   = cmd_address / 4;
                    e_wdata  = cmd_write_data;
                    e_strobe = cmd_write ? cmd_strobe : 32'h0;
                    if (cmd_address % 4 != 0) begin
                        m_cli = 1; e_rdata = 0; e_err = 1; e_to = 0;
                    end else if (cmd_write && cmd_strobe == 0) begin
                        m_cli = 1; e_rdata = 0; e_err = 0; e_to = 0;
                    end else begin
                        m_req = 1;
                    end
                    m_busy = 1;
                end
            end else begin
                if (m_cli && rsp_ready) m_cli = 0;
                if (m_req) begin
                    if (bus.request_ready) begin
                        m_req = 0; m_owed = 1; m_wait = 0; m_to = 0;
                    end
                end else if (m_owed) begin
                    if (bus.response_valid) begin
                        m_owed = 0;
                        if (!m_to) begin
                            m_cli   = 1;
                            e_rdata = m_write ? 32'h0 : bus.read_data;
                            e_err   = bus.error;
                            e_to    = 0;
                        end
                    end else if (!m_to) begin
                        m_wait++;
                        if (T != 0 && m_wait == T) begin
                            m_to = 1; m_cli = 1; e_rdata = 0; e_err = 1; e_to = 1;
                        end
                    end
                end
                m_busy = m_req || m_owed || m_cli;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("request_valid", bus.request_valid, m_req);
        chk("response_ready", bus.response_ready, m_owed);
        chk("rsp_valid", rsp_valid, m_cli);
        if (m_req) begin
            chk("req_address", bus.address, e_addr);
            chk("req_write_data", bus.write_data, e_wdata);
            chk("req_strobe", bus.strobe, e_strobe);
        end
        if (m_cli) begin
            chk("rsp_read_data", rsp_read_data, e_rdata);
            chk("rsp_error", rsp_error, e_err);
            chk("rsp_timeout", rsp_timeout, e_to);
        end
    end

    // ---------------- bench slave ----------------
    initial begin
        logic [31:0] d;
        logic        e;
        bus.request_ready = 0; bus.response_valid = 0; bus.read_data = 0; bus.error = 0;
        forever begin
            @(negedge clk);
            if (bus.request_valid === 1'b1 && rst === 1'b0) begin
                repeat (slv_hold) @(negedge clk);
                bus.request_ready = 1;
                d = slv_data;
                e = slv_err;
                @(negedge clk);
                bus.request_ready = 0;
                if (slv_delay >= 0) begin
                    repeat (slv_delay) @(negedge clk);
                    bus.response_valid = 1; bus.read_data = d; bus.error = e;
                    @(negedge clk);
                    bus.response_valid = 0; bus.read_data = 0; bus.error = 0;
                end
            end
        end
    end

    // ---------------- client tasks ----------------
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [31:0] st);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_address = a; cmd_write_data = wd; cmd_strobe = st;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", n < 300, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int c0);
        int n = 0;
        while (cli_cnt == c0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("response_within_bound", n < 300, 1);
    endtask

    task automatic wait_done(input int c0);
        int n = 0;
        while ((cli_cnt == c0 || cmd_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", n < 300, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_read_data"}, rsp_read_data, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_request_valid"}, bus.request_valid, 0);
        chk({tag, "_response_ready"}, bus.response_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0, r0, h0, h1;
        rst = 1;
        cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_write_data = '0; cmd_strobe = '0;
        rsp_ready = 1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 0;

        // Aligned read, response two cycles after acceptance by the slave.
        slv_hold = 0; slv_delay = 2; slv_data = 32'hDEAD_BEEF; slv_err = 0;
        c0 = cli_cnt;
        issue(0, 14'h0010, 32'h0, 32'hFFFF_FFFF);
        wait_done(c0);
        chk("rd_addr", seen_addr, 12'h004);
        chk("rd_strobe", seen_strobe, 32'h0);
        chk("rd_data", last_rdata, 32'hDEAD_BEEF);
        chk("rd_error", last_err, 0);
        chk("rd_req_latency", hs_cyc - acc_cyc, 1);
        chk("rd_rsp_latency", cli_cyc - hs_cyc, 4);

        // Write with request_ready held low for 5 cycles, slave error.
        slv_hold = 5; slv_delay = 1; slv_data = 32'hFFFF_FFFF; slv_err = 1;
        c0 = cli_cnt; r0 = req_valid_cycles; h0 = req_hs_cnt;
        issue(1, 14'h0020, 32'h1234_5678, 32'h0000_FFFF);
        wait_done(c0);
        chk("wr_addr", seen_addr, 12'h008);
        chk("wr_strobe", seen_strobe, 32'h0000_FFFF);
        chk("wr_data", seen_wdata, 32'h1234_5678);
        chk("wr_valid_cycles", req_valid_cycles - r0, 6);
        chk("wr_handshakes", req_hs_cnt - h0, 1);
        chk("wr_rsp_data", last_rdata, 32'h0);
        chk("wr_rsp_error", last_err, 1);
        chk("wr_rsp_timeout", last_to, 0);

        // Misaligned read: local error, no bus access.
        slv_hold = 0; slv_delay = 0; slv_err = 0;
        c0 = cli_cnt; r0 = req_valid_cycles;
        issue(0, 14'h0013, 32'h0, 32'h0);
        wait_done(c0);
        chk("mis_no_request", req_valid_cycles - r0, 0);
        chk("mis_error", last_err, 1);
        chk("mis_timeout", last_to, 0);
        chk("mis_data", last_rdata, 32'h0);
        chk("mis_latency", cli_cyc - acc_cyc, 1);

        // Zero-strobe write: completes locally without error.
        c0 = cli_cnt; r0 = req_valid_cycles;
        issue(1, 14'h0024, 32'hAAAA_AAAA, 32'h0);
        wait_done(c0);
        chk("zs_no_request", req_valid_cycles - r0, 0);
        chk("zs_error", last_err, 0);
        chk("zs_data", last_rdata, 32'h0);

        // Timeout with a late response 28 cycles after the request handshake.
        slv_delay = 28; slv_data = 32'h5555_5555; slv_err = 0;
        c0 = cli_cnt;
        issue(0, 14'h0030, 32'h0, 32'h0);
        wait_rsp(c0);
        h1 = hs_cyc;
        chk("to_error", last_err, 1);
        chk("to_timeout", last_to, 1);
        chk("to_data", last_rdata, 32'h0);
        chk("to_rsp_latency", cli_cyc - h1, 9);
        slv_delay = 0; slv_data = 32'hCAFE_0001;
        c0 = cli_cnt;
        issue(0, 14'h0040, 32'h0, 32'h0);
        chk("to_next_accept", acc_cyc - h1, 30);
        wait_done(c0);
        chk("to_next_data", last_rdata, 32'hCAFE_0001);
        chk("to_next_timeout", last_to, 0);

        // Response on the expiry cycle is a normal response.
        slv_delay = 7; slv_data = 32'h0000_7777;
        c0 = cli_cnt;
        issue(0, 14'h0050, 32'h0, 32'h0);
        wait_done(c0);
        chk("exp_timeout", last_to, 0);
        chk("exp_error", last_err, 0);
        chk("exp_data", last_rdata, 32'h0000_7777);
        chk("exp_latency", cli_cyc - hs_cyc, 9);

        // One cycle later it is a timeout, with the late response drained at once.
        slv_delay = 8; slv_data = 32'h0000_8888;
        c0 = cli_cnt;
        issue(0, 14'h0054, 32'h0, 32'h0);
        wait_done(c0);
        chk("late1_timeout", last_to, 1);
        chk("late1_data", last_rdata, 32'h0);

        // Reset while waiting for the slave response.
        slv_delay = -1;
        issue(0, 14'h0060, 32'h0, 32'h0);
        begin
            int n = 0;
            while (bus.response_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("wait_state_reached", n < 50, 1);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1 chk_reset_vals("rst_wait");
        @(negedge clk);
        rst = 0;

        // Reset while the client response is held.
        rsp_ready = 0; slv_delay = 0; slv_data = 32'h0000_9999;
        issue(0, 14'h0064, 32'h0, 32'h0);
        begin
            int n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("resp_state_reached", n < 50, 1);
        end
        @(negedge clk);
        #2 rst = 1;
        #1 chk_reset_vals("rst_resp");
        @(negedge clk);
        rst = 0;
        rsp_ready = 1;

        // Normal read after the resets.
        slv_delay = 1; slv_data = 32'h1357_9BDF; slv_err = 0;
        c0 = cli_cnt;
        issue(0, 14'h0068, 32'h0, 32'h0);
        wait_done(c0);
        chk("post_rst_addr", seen_addr, 12'h01A);
        chk("post_rst_data", last_rdata, 32'h1357_9BDF);
        chk("post_rst_error", last_err, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
